thresholding_axilite_loader: RTL and testbench

- AXI-Lite write initiator that programs threshold memories of thresholding cores from an AXI-Stream of threshold values.
- Sits between a weight/threshold DMA or stream source and the `s_axilite` write port of a thresholding AXI adapter.
- Converts each stream beat into exactly one AXI-Lite write. Target addresses are generated in channel-major order.
- One transaction is outstanding at a time. The read channels are not used.

---
 rtl/thresholding_pkg.sv | 13 +
 rtl/thresholding_axilite_loader.sv | 166 ++++++++++++++++
 tb/tb_thresholding_axilite_loader.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thresholding_pkg.sv
// Shared types and AXI constants for the thresholding AXI-Lite loader.
package thresholding_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } loader_state_t;

endpackage

// File: rtl/thresholding_axilite_loader.sv
// Turns each threshold stream beat into one AXI-Lite write, walking
// {channel, index} addresses in channel-major order.
module thresholding_axilite_loader
  import thresholding_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned M      = 16,
  parameter int unsigned C      = 1,
  parameter int unsigned SIGNED = 1,
  localparam int unsigned C_BITS = (C < 2) ? 0 : $clog2(C),
  localparam int unsigned A_BITS = C_BITS + N,
  localparam int unsigned D_BITS = ((M + 7) / 8) * 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [D_BITS-1:0] s_axis_tdata,
  output logic              m_axilite_AWVALID,
  input  logic              m_axilite_AWREADY,
  output logic [A_BITS-1:0] m_axilite_AWADDR,
  output logic              m_axilite_WVALID,
  input  logic              m_axilite_WREADY,
  output logic [31:0]       m_axilite_WDATA,
  output logic [3:0]        m_axilite_WSTRB,
  input  logic              m_axilite_BVALID,
  output logic              m_axilite_BREADY,
  input  logic [1:0]        m_axilite_BRESP,
  output logic              done,
  output logic              err
);

  localparam int unsigned CW = (C_BITS > 0) ? C_BITS : 1;
  localparam int unsigned T  = (2 ** N) - 1;

  loader_state_t state_q, state_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [CW-1:0] cnl_q, cnl_d;
  logic [31:0]   wdata_q, wdata_d, thr_ext;
  logic [M-1:0]  thr;
  logic tready_q, tready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic bready_q, bready_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic beat_acc, issue_done, b_hs, idx_last, cnl_last;

  assign thr        = s_axis_tdata[M-1:0];
  assign beat_acc   = (state_q == IDLE) && tready_q && s_axis_tvalid;
  assign issue_done = (state_q == ISSUE) && (!awvalid_q || m_axilite_AWREADY)
                      && (!wvalid_q || m_axilite_WREADY);
  assign b_hs       = (state_q == RESP) && bready_q && m_axilite_BVALID;
  assign idx_last   = (idx_q == N'(T - 1));
  assign cnl_last   = (cnl_q == CW'(C - 1));

  // Extend the latched threshold to the 32-bit register width
  always_comb begin
    if (SIGNED != 0) thr_ext = 32'($signed(thr));
    else             thr_ext = 32'(thr);
  end

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic: one write in flight at a time
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat_acc)   state_d = ISSUE;
      ISSUE:   if (issue_done) state_d = RESP;
      RESP:    if (b_hs)       state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and the address counter
  always_comb begin
    tready_d  = (state_d == IDLE);
    bready_d  = (state_d == RESP);
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    idx_d     = idx_q;
    cnl_d     = cnl_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (beat_acc) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          wdata_d   = thr_ext;
        end
      end
      ISSUE: begin
        awvalid_d = awvalid_q && !m_axilite_AWREADY;
        wvalid_d  = wvalid_q && !m_axilite_WREADY;
      end
      RESP: begin
        if (b_hs) begin
          if (m_axilite_BRESP != RESP_OKAY) err_d = 1'b1;
          if (idx_last) begin
            idx_d = '0;
            if (cnl_last) begin
              cnl_d  = '0;
              done_d = 1'b1;
            end else begin
              cnl_d = cnl_q + CW'(1);
            end
          end else begin
            idx_d = idx_q + N'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Output, data and counter registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      cnl_q     <= '0;
      wdata_q   <= '0;
    end else begin
      tready_q  <= tready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      cnl_q     <= cnl_d;
      wdata_q   <= wdata_d;
    end
  end

  // Address is the channel counter above the index; no channel field for C=1
  generate
    if (C_BITS > 0) begin : g_addr_cnl
      assign m_axilite_AWADDR = {cnl_q[C_BITS-1:0], idx_q};
    end else begin : g_addr_idx
      assign m_axilite_AWADDR = idx_q;
    end
  endgenerate

  assign s_axis_tready     = tready_q;
  assign m_axilite_AWVALID = awvalid_q;
  assign m_axilite_WVALID  = wvalid_q;
  assign m_axilite_WDATA   = wdata_q;
  assign m_axilite_WSTRB   = 4'hF;
  assign m_axilite_BREADY  = bready_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_thresholding_axilite_loader.sv
// Bench: dut0 is N=2,M=8,C=3,SIGNED=1; dut1 is N=1,M=8,C=1,SIGNED=0 sharing
// the same stream and AXI responder inputs.
module tb_thresholding_axilite_loader;
  import thresholding_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic        s_axis_tvalid = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        tready0, tready1;
  logic        AWVALID0, AWVALID1, WVALID0, WVALID1, BREADY0, BREADY1;
  logic        AWREADY, WREADY, BVALID;
  logic [1:0]  BRESP;
  logic [3:0]  AWADDR0;
  logic [0:0]  AWADDR1;
  logic [31:0] WDATA0, WDATA1;
  logic [3:0]  WSTRB0, WSTRB1;
  logic        done0, done1, err0, err1;

  thresholding_axilite_loader #(.N(2), .M(8), .C(3), .SIGNED(1)) dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready0), .s_axis_tdata(s_axis_tdata),
    .m_axilite_AWVALID(AWVALID0), .m_axilite_AWREADY(AWREADY), .m_axilite_AWADDR(AWADDR0),
    .m_axilite_WVALID(WVALID0), .m_axilite_WREADY(WREADY), .m_axilite_WDATA(WDATA0),
    .m_axilite_WSTRB(WSTRB0), .m_axilite_BVALID(BVALID), .m_axilite_BREADY(BREADY0),
    .m_axilite_BRESP(BRESP), .done(done0), .err(err0));

  thresholding_axilite_loader #(.N(1), .M(8), .C(1), .SIGNED(0)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready1), .s_axis_tdata(s_axis_tdata),
    .m_axilite_AWVALID(AWVALID1), .m_axilite_AWREADY(AWREADY), .m_axilite_AWADDR(AWADDR1),
    .m_axilite_WVALID(WVALID1), .m_axilite_WREADY(WREADY), .m_axilite_WDATA(WDATA1),
    .m_axilite_WSTRB(WSTRB1), .m_axilite_BVALID(BVALID), .m_axilite_BREADY(BREADY1),
    .m_axilite_BRESP(BRESP), .done(done1), .err(err1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Responder configuration and state
  int   aw_delay = 0, w_delay = 0, b_delay = 0, err_at = 0;
  int   aw_cnt, w_cnt, b_cnt, bcnt;
  logic aw_fire_q, w_fire_q, b_fire_q, aw_done, w_done, err_exp;
  logic exp_done0, exp_done1;
  int   done_cnt0 = 0, done_cnt1 = 0;

  // Scoreboard
  logic [3:0]  exp_addr_q[$];
  logic [31:0] exp_d0_q[$];
  logic [31:0] exp_d1_q[$];
  int          acc_cyc_q[$];
  int          sb_k = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // AXI-Lite responder and monitor, acting on the falling edge
  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = RESP_OKAY;
    aw_fire_q = 0; w_fire_q = 0; b_fire_q = 0; aw_done = 0; w_done = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; bcnt = 0; err_exp = 0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = RESP_OKAY;
        aw_fire_q = 0; w_fire_q = 0; b_fire_q = 0; aw_done = 0; w_done = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; bcnt = 0; err_exp = 0;
      end else begin
        if (aw_fire_q) begin
          aw_done = 1;
          checks++;
          if (AWVALID0 !== 1'b0) begin
            errors++; $display("FAIL aw_drop: AWVALID=%b want 0 after handshake", AWVALID0);
          end
        end
        if (w_fire_q) begin
          w_done = 1;
          checks++;
          if (WVALID0 !== 1'b0) begin
            errors++; $display("FAIL w_drop: WVALID=%b want 0 after handshake", WVALID0);
          end
        end
        if (b_fire_q) begin
          bcnt++;
          if (BRESP != RESP_OKAY) err_exp = 1;
          aw_done = 0; w_done = 0; b_cnt = 0;
        end
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
        exp_done0 = b_fire_q && (bcnt % 9 == 0);
        exp_done1 = b_fire_q;
        checks++;
        if ({done0, done1} !== {exp_done0, exp_done1}) begin
          errors++; $display("FAIL done: got %b%b want %b%b at cyc %0d", done0, done1, exp_done0, exp_done1, cyc);
        end
        checks++;
        if ({err0, err1} !== {err_exp, err_exp}) begin
          errors++; $display("FAIL err: got %b%b want %b%b at cyc %0d", err0, err1, err_exp, err_exp, cyc);
        end
        checks++;
        if ((AWVALID0 || WVALID0) && (BREADY0 !== 1'b0)) begin
          errors++; $display("FAIL bready_early: BREADY=%b while AW/W pending", BREADY0);
        end
        checks++;
        if ((AWVALID0 || WVALID0 || BREADY0) && (tready0 !== 1'b0)) begin
          errors++; $display("FAIL tready_busy: tready=%b want 0 mid-transaction", tready0);
        end
        if (AWVALID0) begin
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++; $display("FAIL aw_unexpected: AWADDR=%0d with no expected write", AWADDR0);
          end else if (AWADDR0 !== exp_addr_q[0]) begin
            errors++; $display("FAIL awaddr: got %0d want %0d", AWADDR0, exp_addr_q[0]);
          end
        end
        if (WVALID0) begin
          checks++;
          if (exp_d0_q.size() == 0) begin
            errors++; $display("FAIL w_unexpected: WDATA=%h with no expected write", WDATA0);
          end else if (WVALID1 !== 1'b1 || WDATA0 !== exp_d0_q[0] || WDATA1 !== exp_d1_q[0]) begin
            errors++; $display("FAIL wdata: got %h/%h(v%b) want %h/%h", WDATA0, WDATA1, WVALID1, exp_d0_q[0], exp_d1_q[0]);
          end
        end
        // Handshake decisions for the next rising edge
        if (AWVALID0 && !aw_done) begin AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin AWREADY = 0; aw_cnt = 0; end
        if (WVALID0 && !w_done) begin WREADY = (w_cnt >= w_delay); w_cnt++; end
        else begin WREADY = 0; w_cnt = 0; end
        aw_fire_q = AWVALID0 && AWREADY;
        w_fire_q  = WVALID0 && WREADY;
        if (aw_fire_q) begin
          checks++;
          if (AWVALID1 !== 1'b1 || AWADDR1 !== 1'b0) begin
            errors++; $display("FAIL awaddr1: got %b(v%b) want 0(v1)", AWADDR1, AWVALID1);
          end
          if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
        end
        if (w_fire_q) begin
          if (exp_d0_q.size() > 0) void'(exp_d0_q.pop_front());
          if (exp_d1_q.size() > 0) void'(exp_d1_q.pop_front());
        end
        if (aw_done && w_done) begin
          BVALID = (b_cnt >= b_delay);
          BRESP  = (bcnt + 1 == err_at) ? RESP_SLVERR : RESP_OKAY;
          b_cnt++;
        end else begin
          BVALID = 0;
        end
        b_fire_q = BVALID && BREADY0;
      end
    end
  end

  task automatic step();
    @(negedge ap_clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] v);
    int idx, cnl;
    idx = sb_k % 3;
    cnl = (sb_k / 3) % 3;
    exp_addr_q.push_back(4'(cnl * 4 + idx));
    exp_d0_q.push_back({{24{v[7]}}, v});
    exp_d1_q.push_back({24'h0, v});
    sb_k++;
  endtask

  task automatic send_beats(input int n, input logic [7:0] first);
    for (int b = 0; b < n; b++) begin
      int w;
      w = 0;
      s_axis_tdata  = first + 8'(b);
      s_axis_tvalid = 1'b1;
      while (tready0 !== 1'b1 && w < 200) begin step(); w++; end
      checks++;
      if (tready0 !== 1'b1) begin
        errors++; $display("FAIL accept_timeout: tready=%b want 1", tready0);
        s_axis_tvalid = 1'b0;
        return;
      end
      push_exp(s_axis_tdata);
      acc_cyc_q.push_back(cyc);
      step();
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (tready0 !== 1'b1 && w < 200) begin step(); w++; end
    checks++;
    if (tready0 !== 1'b1) begin
      errors++; $display("FAIL idle_timeout: tready=%b want 1", tready0);
    end
  endtask

  task automatic apply_reset();
    ap_rst_n = 1'b0;
    step(); step();
    exp_addr_q.delete(); exp_d0_q.delete(); exp_d1_q.delete();
    sb_k = 0;
    ap_rst_n = 1'b1;
    step(); step();
    checks++;
    if ({err0, err1, tready0} !== 3'b001) begin
      errors++; $display("FAIL reset_clear: err=%b%b tready=%b want 00/1", err0, err1, tready0);
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    step(); step();
    checks++;
    if ({tready0, AWVALID0, WVALID0, BREADY0, done0, err0} !== 6'b0) begin
      errors++; $display("FAIL reset_dut0: got %b want 000000", {tready0, AWVALID0, WVALID0, BREADY0, done0, err0});
    end
    checks++;
    if ({tready1, AWVALID1, WVALID1, BREADY1, done1, err1} !== 6'b0) begin
      errors++; $display("FAIL reset_dut1: got %b want 000000", {tready1, AWVALID1, WVALID1, BREADY1, done1, err1});
    end
    checks++;
    if (WSTRB0 !== 4'hF || WSTRB1 !== 4'hF) begin
      errors++; $display("FAIL wstrb: got %h/%h want f/f", WSTRB0, WSTRB1);
    end
    ap_rst_n = 1'b1;
    step(); step();
    checks++;
    if (tready0 !== 1'b1) begin
      errors++; $display("FAIL tready_after_reset: got %b want 1", tready0);
    end
  endtask

  task automatic test_full_sweep();
    int d0, d1;
    d0 = done_cnt0; d1 = done_cnt1;
    acc_cyc_q.delete();
    send_beats(9, 8'd1);
    wait_idle();
    step();
    checks++;
    if (done_cnt0 - d0 != 1 || done_cnt1 - d1 != 9) begin
      errors++; $display("FAIL sweep_done: pulses %0d/%0d want 1/9", done_cnt0 - d0, done_cnt1 - d1);
    end
    for (int i = 1; i < acc_cyc_q.size(); i++) begin
      checks++;
      if (acc_cyc_q[i] - acc_cyc_q[i-1] != 3) begin
        errors++; $display("FAIL throughput: beat %0d gap %0d want 3", i, acc_cyc_q[i] - acc_cyc_q[i-1]);
      end
    end
    checks++;
    if (exp_addr_q.size() != 0 || exp_d0_q.size() != 0) begin
      errors++; $display("FAIL sweep_drain: %0d/%0d writes missing want 0/0", exp_addr_q.size(), exp_d0_q.size());
    end
  endtask

  task automatic test_sign_extension();
    send_beats(1, 8'h80);
    checks++;
    if (WDATA0 !== 32'hFFFFFF80 || WDATA1 !== 32'h00000080) begin
      errors++; $display("FAIL sign_80: got %h/%h want ffffff80/00000080", WDATA0, WDATA1);
    end
    wait_idle();
    send_beats(1, 8'h7F);
    checks++;
    if (WDATA0 !== 32'h0000007F || WDATA1 !== 32'h0000007F) begin
      errors++; $display("FAIL sign_7f: got %h/%h want 0000007f/0000007f", WDATA0, WDATA1);
    end
    wait_idle();
  endtask

  task automatic test_split(input int awd, input int wd);
    int b0, w;
    logic aw_only, w_only;
    aw_delay = awd; w_delay = wd;
    b0 = bcnt; aw_only = 0; w_only = 0; w = 0;
    send_beats(1, 8'h33);
    while (tready0 !== 1'b1 && w < 100) begin
      if (AWVALID0 && !WVALID0) aw_only = 1;
      if (WVALID0 && !AWVALID0) w_only = 1;
      step(); w++;
    end
    checks++;
    if ({aw_only, w_only} !== ((awd > wd) ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL split_order(%0d,%0d): aw_only/w_only %b%b want %b",
                         awd, wd, aw_only, w_only, (awd > wd) ? 2'b10 : 2'b01);
    end
    checks++;
    if (bcnt - b0 != 1) begin
      errors++; $display("FAIL split_b(%0d,%0d): %0d responses want 1", awd, wd, bcnt - b0);
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_error_response();
    int d0;
    apply_reset();
    err_at = 2;
    d0 = done_cnt0;
    send_beats(9, 8'h10);
    wait_idle();
    step();
    checks++;
    if (err0 !== 1'b1 || done_cnt0 - d0 != 1) begin
      errors++; $display("FAIL error_sweep: err=%b done pulses %0d want 1/1", err0, done_cnt0 - d0);
    end
    err_at = 0;
  endtask

  task automatic test_backpressure();
    int b0;
    b_delay = 10;
    acc_cyc_q.delete();
    b0 = bcnt;
    send_beats(2, 8'h40);
    wait_idle();
    checks++;
    if (acc_cyc_q.size() != 2 || acc_cyc_q[1] - acc_cyc_q[0] != 13) begin
      errors++; $display("FAIL backpressure_gap: got %0d want 13",
                         (acc_cyc_q.size() == 2) ? acc_cyc_q[1] - acc_cyc_q[0] : -1);
    end
    checks++;
    if (bcnt - b0 != 2 || err0 !== 1'b1) begin
      errors++; $display("FAIL backpressure_b: %0d responses err=%b want 2/1", bcnt - b0, err0);
    end
    b_delay = 0;
  endtask

  task automatic test_reset_mid_issue();
    apply_reset();
    send_beats(4, 8'h50);
    wait_idle();
    aw_delay = 50;
    send_beats(1, 8'h60);
    step();
    checks++;
    if (AWVALID0 !== 1'b1 || AWADDR0 !== 4'd5) begin
      errors++; $display("FAIL mid_setup: AWVALID=%b AWADDR=%0d want 1/5", AWVALID0, AWADDR0);
    end
    #1 ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({AWVALID0, WVALID0, AWVALID1, WVALID1} !== 4'b0) begin
      errors++; $display("FAIL async_reset: valids %b want 0000", {AWVALID0, WVALID0, AWVALID1, WVALID1});
    end
    step(); step();
    exp_addr_q.delete(); exp_d0_q.delete(); exp_d1_q.delete();
    sb_k = 0;
    aw_delay = 0;
    ap_rst_n = 1'b1;
    step(); step();
    send_beats(1, 8'h61);
    checks++;
    if (AWVALID0 !== 1'b1 || AWADDR0 !== 4'd0) begin
      errors++; $display("FAIL post_reset_addr: AWVALID=%b AWADDR=%0d want 1/0", AWVALID0, AWADDR0);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_sign_extension();
    test_split(3, 0);
    test_split(0, 3);
    test_error_response();
    test_backpressure();
    test_reset_mid_issue();
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
